// File: rtl/taus_urng_bank_if.sv
`timescale 1ns/1ps
// Seed-load, control and uniform-output bundle of the taus88 bank.
// Latency: none (wires only).
// Backpressure: seed_valid/seed_ready handshake. The u0..u5 outputs have no ready; the consumer must take each u_valid word.
// Ports: seed_valid/seed_data/seed_ready load seeds; start/restart/enable are the controls;
//        u0..u5 with u_valid carry the uniforms; seed_err and state_o report status.
interface taus_urng_bank_if;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        seed_ready;
  logic        start;
  logic        restart;
  logic        enable;
  logic [31:0] u0;
  logic [31:0] u1;
  logic [31:0] u2;
  logic [31:0] u3;
  logic [31:0] u4;
  logic [31:0] u5;
  logic        u_valid;
  logic        seed_err;
  logic [1:0]  state_o;

  modport master (
    output seed_valid, seed_data, start, restart, enable,
    input  seed_ready, u0, u1, u2, u3, u4, u5, u_valid, seed_err, state_o
  );

  modport slave (
    input  seed_valid, seed_data, start, restart, enable,
    output seed_ready, u0, u1, u2, u3, u4, u5, u_valid, seed_err, state_o
  );
endinterface

// File: rtl/taus_urng_bank.sv
`timescale 1ns/1ps
// Bank of six taus88 uniform generators feeding the AWGN s0..s5 inputs.
// Latency: u_valid follows an enabled RUN cycle by one clock; WARMUP_CYCLES steps are discarded after seeding.
// Backpressure: seed_ready is high only in IDLE while words remain; enable=0 in RUN freezes the generators and the outputs.
// Ports: clk (rising edge), reset (async, active-low), bus (slave side of taus_urng_bank_if).
module taus_urng_bank #(
  parameter int WARMUP_CYCLES = 64,
  parameter int NUM_GEN       = 6
) (
  input  logic             clk,
  input  logic             reset,
  taus_urng_bank_if.slave  bus
);

  localparam int NUM_WORDS = 3 * NUM_GEN;
  localparam int WCW       = (WARMUP_CYCLES > 2) ? $clog2(WARMUP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_t;

  // With no warm-up configured the bank goes straight to RUN.
  localparam state_t START_ST = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

  // Word n belongs to generator n/3, component n%3.
  function automatic logic [31:0] dflt(input int n);
    return 32'(100 * (n + 1) + 16);
  endfunction

  // Component minimums: a state below these collapses the taus88 recurrence.
  function automatic logic [31:0] seed_min(input int n);
    case (n % 3)
      0:       return 32'd2;
      1:       return 32'd8;
      default: return 32'd16;
    endcase
  endfunction

  function automatic logic [31:0] taus_s1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] taus_s2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] taus_s3(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WCW-1:0]   r_warm;
  logic [31:0]      r_w [NUM_WORDS];
  logic [31:0]      r_u [NUM_GEN];
  logic             r_u_vld;
  logic             r_seed_err;

  logic [31:0]          w_nxt [NUM_WORDS];
  logic [31:0]          w_u   [NUM_GEN];
  logic [NUM_WORDS-1:0] w_below;
  logic                 w_seed_ready;
  logic                 w_seed_acc;
  logic                 w_warm_done;

  always_comb begin
    for (int g = 0; g < NUM_GEN; g++) begin
      w_nxt[3*g]   = taus_s1(r_w[3*g]);
      w_nxt[3*g+1] = taus_s2(r_w[3*g+1]);
      w_nxt[3*g+2] = taus_s3(r_w[3*g+2]);
      w_u[g]       = w_nxt[3*g] ^ w_nxt[3*g+1] ^ w_nxt[3*g+2];
    end
    w_below = '0;
    for (int n = 0; n < NUM_WORDS; n++) begin
      w_below[n] = (r_w[n] < seed_min(n));
    end
  end

  assign w_seed_ready = (r_state == IDLE) && (r_cnt < 5'(NUM_WORDS));
  assign w_seed_acc   = bus.seed_valid && w_seed_ready;
  assign w_warm_done  = (r_warm == WCW'(WARMUP_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= 5'd0;
      r_warm     <= '0;
      r_u_vld    <= 1'b0;
      r_seed_err <= 1'b0;
      for (int n = 0; n < NUM_WORDS; n++) r_w[n] <= dflt(n);
      for (int g = 0; g < NUM_GEN; g++)   r_u[g] <= 32'd0;
    end else if (bus.restart) begin
      // State words, outputs and seed_err survive a restart.
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_warm  <= '0;
      r_u_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_u_vld <= 1'b0;
          // start with nothing loaded reuses the current words; a seed
          // word offered in that same cycle is dropped.
          if (bus.start && (r_cnt == 5'd0)) begin
            r_state <= START_ST;
            r_warm  <= '0;
          end else if (w_seed_acc) begin
            r_w[r_cnt] <= bus.seed_data;
            r_cnt      <= r_cnt + 5'd1;
            if (r_cnt == 5'(NUM_WORDS - 1)) r_state <= CHECK;
          end
        end
        CHECK: begin
          for (int n = 0; n < NUM_WORDS; n++) begin
            if (w_below[n]) r_w[n] <= dflt(n);
          end
          r_seed_err <= |w_below;
          r_warm     <= '0;
          r_state    <= START_ST;
        end
        WARMUP: begin
          for (int n = 0; n < NUM_WORDS; n++) r_w[n] <= w_nxt[n];
          r_warm <= r_warm + 1'b1;
          if (w_warm_done) r_state <= RUN;
        end
        RUN: begin
          if (bus.enable) begin
            for (int n = 0; n < NUM_WORDS; n++) r_w[n] <= w_nxt[n];
            for (int g = 0; g < NUM_GEN; g++)   r_u[g] <= w_u[g];
            r_u_vld <= 1'b1;
          end else begin
            r_u_vld <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.seed_ready = w_seed_ready;
  assign bus.u0         = r_u[0];
  assign bus.u1         = r_u[1];
  assign bus.u2         = r_u[2];
  assign bus.u3         = r_u[3];
  assign bus.u4         = r_u[4];
  assign bus.u5         = r_u[5];
  assign bus.u_valid    = r_u_vld;
  assign bus.seed_err   = r_seed_err;
  assign bus.state_o    = r_state;

endmodule

// File: doc/taus_urng_bank.md
TAUS_URNG_BANK -- requirements
Module: taus_urng_bank

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 64, meaning the number of generator steps discarded after seeding.
REQ-002 SHALL have parameter NUM_GEN, fixed at 6, meaning the number of independent taus88 generators (one per AWGN uniform input s0..s5).
REQ-003 SHALL have port clk, input, 1, the clock; all flops are rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port seed_valid, input, 1, seed word present.
REQ-006 SHALL have port seed_data, input, 32, seed word.
REQ-007 SHALL have port seed_ready, output, 1, bank accepts a seed word this cycle.
REQ-008 SHALL have port start, input, 1, single-cycle pulse that begins warm-up.
REQ-009 SHALL have port restart, input, 1, single-cycle pulse that returns the bank to IDLE.
REQ-010 SHALL have port enable, input, 1, allows generator stepping in RUN.
REQ-011 SHALL have ports u0..u5, output, 32 each, registered uniform words that feed AWGN s0..s5.
REQ-012 SHALL have port u_valid, output, 1, u0..u5 updated this cycle.
REQ-013 SHALL have port seed_err, output, 1, a loaded seed component was below its minimum and was replaced.
REQ-014 SHALL have port state_o, output, 2, current state: IDLE=0, CHECK=1, WARMUP=2, RUN=3.

Function
REQ-015 SHALL hold 18 state words: generator k (0..5), component j (0..2).
REQ-016 SHALL use default seed = 100*(3k+j+1)+16 (decimal) for each word.
REQ-017 SHALL step each generator per taus88: s1'=((s1&FFFFFFFE)<<12)^(((s1<<13)^s1)>>19); s2'=((s2&FFFFFFF8)<<4)^(((s2<<2)^s2)>>25); s3'=((s3&FFFFFFF0)<<17)^(((s3<<3)^s3)>>11); all logical shifts, 32-bit truncation; output u=s1'^s2'^s3'.
REQ-018 SHALL make IDLE the reset state, with seed_ready=1 while the seed count <18.
REQ-019 SHALL, in IDLE, on seed_valid&seed_ready, write seed_data to word n = seed count (generator n/3, component n%3) and increment the count.
REQ-020 SHALL go to CHECK on the cycle the 18th word is accepted; seed_ready is then 0.
REQ-021 SHALL go to WARMUP when start is asserted in IDLE with count=0, using the current state words and skipping CHECK.
REQ-022 SHALL ignore start in IDLE while 0<count<18.
REQ-023 SHALL, in CHECK (exactly 1 cycle), replace any component with s1<2, s2<8 or s3<16 by its default, set seed_err=1 if any replacement occurred (else 0), then go to WARMUP.
REQ-024 SHALL, in WARMUP, step all generators every cycle regardless of enable, keep u_valid=0 and outputs unchanged, and go to RUN after WARMUP_CYCLES steps.
REQ-025 SHALL, in RUN with enable=1, step all generators, register u_k, and assert u_valid=1 on the next cycle; with enable=0, hold state and outputs and drive u_valid=0.
REQ-026 SHALL make the first u_valid occur 1 cycle after the first enabled RUN cycle.
REQ-027 SHALL, on restart in any state, go to IDLE next cycle with count=0, u_valid=0, and state words retained; restart has priority over start and seed_valid in the same cycle.
REQ-028 SHALL hold seed_ready=0 and ignore seed_valid outside IDLE.
REQ-029 SHALL clear seed_err only on a new CHECK or on reset.

Reset
REQ-030 SHALL, on reset assertion, immediately set: state=IDLE, count=0, warm-up counter=0, state words=defaults, u0..u5=0, u_valid=0, seed_err=0, seed_ready=1.
REQ-031 SHALL behave identically for reset asserted mid-load or mid-RUN, discarding any partial seeds.

Verification
REQ-032 Reset, start pulse, enable=1 -> state_o 0->2, 64 cycles with u_valid=0, then 3; u0..u5 match the software taus88 model seeded with defaults from step 65 onward.
REQ-033 Load 18 words with word 0 = 1 -> CHECK replaces gen0.s1 with 116, seed_err=1; sequence matches the model using 116.
REQ-034 Load 18 valid words (all >=16) -> seed_err=0; the first valid outputs match the model after 64 discarded steps.
REQ-035 In RUN, toggle enable 1,0,0,1 -> u_valid 1,0,0,1 delayed by one cycle; held outputs are unchanged and the sequence has no gaps.
REQ-036 Load 7 words, pulse start, then restart, then load 18 words -> start is ignored, count resets, and the new seeds take effect.
REQ-037 Assert reset mid-WARMUP -> all outputs return to their REQ-030 values asynchronously.
